// File: rtl/score_system_test_pkg.sv
// Shared constants, encodings and saturating helpers for the rhythm-game scorer.
package score_system_test_pkg;

    localparam int SCORE_W = 14;
    localparam int TIMER_W = 20;
    localparam int BTN_W   = 4;

    // Default timing windows, measured in clock cycles at 50 MHz.
    localparam int unsigned DEF_PERFECT_WINDOW = 125000;
    localparam int unsigned DEF_GOOD_WINDOW    = 250000;
    localparam int unsigned DEF_TOTAL_WINDOW   = 500000;

    // Default point values and score ceiling.
    localparam int unsigned DEF_PERFECT_POINTS = 10;
    localparam int unsigned DEF_GOOD_POINTS    = 5;
    localparam int unsigned DEF_PENALTY_POINTS = 5;
    localparam int unsigned DEF_SCORE_MAX      = 9999;

    // One-hot button encodings shared by both players.
    localparam logic [BTN_W-1:0] BTN_NONE  = 4'b0000;
    localparam logic [BTN_W-1:0] BTN_UP    = 4'b0001;
    localparam logic [BTN_W-1:0] BTN_DOWN  = 4'b0010;
    localparam logic [BTN_W-1:0] BTN_LEFT  = 4'b0100;
    localparam logic [BTN_W-1:0] BTN_RIGHT = 4'b1000;

    // Per-press result reported on last_hit.
    typedef enum logic [1:0] {
        HIT_MISS    = 2'b00,
        HIT_GOOD    = 2'b01,
        HIT_PERFECT = 2'b10,
        HIT_WRONG   = 2'b11
    } hit_t;

    // Game outcome reported on winner.
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_A    = 2'b01,
        WIN_B    = 2'b10,
        WIN_TIE  = 2'b11
    } winner_t;

    // Add points, clamping at the score ceiling.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] points,
        input logic [SCORE_W-1:0] limit
    );
        logic [SCORE_W:0] sum;
        sum = {1'b0, value} + {1'b0, points};
        if (sum > {1'b0, limit}) begin
            return limit;
        end
        return sum[SCORE_W-1:0];
    endfunction

    // Subtract points, clamping at zero.
    function automatic logic [SCORE_W-1:0] sat_sub(
        input logic [SCORE_W-1:0] value,
        input logic [SCORE_W-1:0] points
    );
        if (value < points) begin
            return '0;
        end
        return value - points;
    endfunction

    // Compare two final scores and name the winner.
    function automatic winner_t decide_winner(
        input logic [SCORE_W-1:0] score_a,
        input logic [SCORE_W-1:0] score_b
    );
        if (score_a > score_b) begin
            return WIN_A;
        end
        if (score_b > score_a) begin
            return WIN_B;
        end
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/score_system_test_score_tracker.sv
// Per-player scorer: detects a fresh press, grades it against the timing
// windows and keeps the running score plus a one-cycle last_hit pulse.
module score_tracker
    import score_system_test_pkg::*;
#(
    parameter int unsigned PERFECT_WINDOW = DEF_PERFECT_WINDOW,
    parameter int unsigned GOOD_WINDOW    = DEF_GOOD_WINDOW,
    parameter int unsigned TOTAL_WINDOW   = DEF_TOTAL_WINDOW,
    parameter int unsigned PERFECT_POINTS = DEF_PERFECT_POINTS,
    parameter int unsigned GOOD_POINTS    = DEF_GOOD_POINTS,
    parameter int unsigned PENALTY_POINTS = DEF_PENALTY_POINTS,
    parameter int unsigned SCORE_MAX      = DEF_SCORE_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BTN_W-1:0]     btn,
    input  logic [BTN_W-1:0]     pattern,
    input  logic [TIMER_W-1:0]   timer,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           last_hit
);

    localparam logic [TIMER_W-1:0] PERFECT_LIM = TIMER_W'(PERFECT_WINDOW);
    localparam logic [TIMER_W-1:0] GOOD_LIM    = TIMER_W'(GOOD_WINDOW);
    localparam logic [TIMER_W-1:0] TOTAL_LIM   = TIMER_W'(TOTAL_WINDOW);
    localparam logic [SCORE_W-1:0] PERFECT_PTS = SCORE_W'(PERFECT_POINTS);
    localparam logic [SCORE_W-1:0] GOOD_PTS    = SCORE_W'(GOOD_POINTS);
    localparam logic [SCORE_W-1:0] PENALTY_PTS = SCORE_W'(PENALTY_POINTS);
    localparam logic [SCORE_W-1:0] MAX_SCORE   = SCORE_W'(SCORE_MAX);

    logic [BTN_W-1:0]   prev_btn;
    logic               press;
    hit_t               hit_kind;
    hit_t               hit_reg;
    logic [SCORE_W-1:0] score_next;

    // Remember last cycle's buttons unconditionally so a held button never re-fires.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_btn <= BTN_NONE;
        end else begin
            prev_btn <= btn;
        end
    end

    assign press = (btn != BTN_NONE) && (prev_btn == BTN_NONE);

    // Grade a fresh press by correctness and elapsed time, and compute the new score.
    always_comb begin
        hit_kind   = HIT_MISS;
        score_next = score;
        if (enable && press) begin
            if (btn == pattern) begin
                if (timer <= PERFECT_LIM) begin
                    hit_kind   = HIT_PERFECT;
                    score_next = sat_add(score, PERFECT_PTS, MAX_SCORE);
                end else if (timer <= GOOD_LIM) begin
                    hit_kind   = HIT_GOOD;
                    score_next = sat_add(score, GOOD_PTS, MAX_SCORE);
                end
            end else if (timer <= TOTAL_LIM) begin
                hit_kind   = HIT_WRONG;
                score_next = sat_sub(score, PENALTY_PTS);
            end
        end
    end

    // Commit the score and the single-cycle hit report at the sampling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score   <= '0;
            hit_reg <= HIT_MISS;
        end else begin
            score   <= score_next;
            hit_reg <= hit_kind;
        end
    end

    assign last_hit = hit_reg;

endmodule

// File: rtl/score_system_test.sv
// Two-player scoring top: one tracker per player, plus the game-over latch
// that captures final scores and decides the winner exactly once.
module score_system_test
    import score_system_test_pkg::*;
#(
    parameter int unsigned PERFECT_WINDOW = DEF_PERFECT_WINDOW,
    parameter int unsigned GOOD_WINDOW    = DEF_GOOD_WINDOW,
    parameter int unsigned TOTAL_WINDOW   = DEF_TOTAL_WINDOW,
    parameter int unsigned PERFECT_POINTS = DEF_PERFECT_POINTS,
    parameter int unsigned GOOD_POINTS    = DEF_GOOD_POINTS,
    parameter int unsigned PENALTY_POINTS = DEF_PENALTY_POINTS,
    parameter int unsigned SCORE_MAX      = DEF_SCORE_MAX
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 game_active,
    input  logic                 game_over,
    input  logic [BTN_W-1:0]     a_input,
    input  logic [BTN_W-1:0]     b_input,
    input  logic [BTN_W-1:0]     pattern_a,
    input  logic [BTN_W-1:0]     pattern_b,
    input  logic                 pattern_valid,
    input  logic [TIMER_W-1:0]   pattern_timer,
    output logic [SCORE_W-1:0]   score_a,
    output logic [SCORE_W-1:0]   score_b,
    output logic [1:0]           last_hit_a,
    output logic [1:0]           last_hit_b,
    output logic [1:0]           winner,
    output logic [SCORE_W-1:0]   final_score_a,
    output logic [SCORE_W-1:0]   final_score_b
);

    logic    score_enable;
    logic    over_seen;
    winner_t winner_reg;
    winner_t winner_next;

    // Game over freezes both players by removing their scoring enable.
    assign score_enable = game_active && pattern_valid && !game_over;

    score_tracker #(
        .PERFECT_WINDOW (PERFECT_WINDOW),
        .GOOD_WINDOW    (GOOD_WINDOW),
        .TOTAL_WINDOW   (TOTAL_WINDOW),
        .PERFECT_POINTS (PERFECT_POINTS),
        .GOOD_POINTS    (GOOD_POINTS),
        .PENALTY_POINTS (PENALTY_POINTS),
        .SCORE_MAX      (SCORE_MAX)
    ) u_tracker_a (
        .clock    (clock),
        .reset    (reset),
        .enable   (score_enable),
        .btn      (a_input),
        .pattern  (pattern_a),
        .timer    (pattern_timer),
        .score    (score_a),
        .last_hit (last_hit_a)
    );

    score_tracker #(
        .PERFECT_WINDOW (PERFECT_WINDOW),
        .GOOD_WINDOW    (GOOD_WINDOW),
        .TOTAL_WINDOW   (TOTAL_WINDOW),
        .PERFECT_POINTS (PERFECT_POINTS),
        .GOOD_POINTS    (GOOD_POINTS),
        .PENALTY_POINTS (PENALTY_POINTS),
        .SCORE_MAX      (SCORE_MAX)
    ) u_tracker_b (
        .clock    (clock),
        .reset    (reset),
        .enable   (score_enable),
        .btn      (b_input),
        .pattern  (pattern_b),
        .timer    (pattern_timer),
        .score    (score_b),
        .last_hit (last_hit_b)
    );

    // Winner candidate from the live scores, used only at the latch moment.
    always_comb begin
        winner_next = decide_winner(score_a, score_b);
    end

    // Latch final scores and winner on the first game-over cycle; hold until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            over_seen     <= 1'b0;
            winner_reg    <= WIN_NONE;
            final_score_a <= '0;
            final_score_b <= '0;
        end else if (game_over && !over_seen) begin
            over_seen     <= 1'b1;
            winner_reg    <= winner_next;
            final_score_a <= score_a;
            final_score_b <= score_b;
        end
    end

    assign winner = winner_reg;

endmodule

// File: tb/tb_score_system_test.sv
// Directed bench for score_system_test: walks the scoring, saturation,
// game-over latch and reset behaviour with hand-computed expectations.
module tb_score_system_test;

    logic        clock;
    logic        reset;
    logic        game_active;
    logic        game_over;
    logic [3:0]  a_input;
    logic [3:0]  b_input;
    logic [3:0]  pattern_a;
    logic [3:0]  pattern_b;
    logic        pattern_valid;
    logic [19:0] pattern_timer;
    logic [13:0] score_a;
    logic [13:0] score_b;
    logic [1:0]  last_hit_a;
    logic [1:0]  last_hit_b;
    logic [1:0]  winner;
    logic [13:0] final_score_a;
    logic [13:0] final_score_b;

    int checks;
    int errors;

    localparam logic [3:0] UP   = 4'b0001;
    localparam logic [3:0] DOWN = 4'b0010;

    score_system_test dut (
        .clock         (clock),
        .reset         (reset),
        .game_active   (game_active),
        .game_over     (game_over),
        .a_input       (a_input),
        .b_input       (b_input),
        .pattern_a     (pattern_a),
        .pattern_b     (pattern_b),
        .pattern_valid (pattern_valid),
        .pattern_timer (pattern_timer),
        .score_a       (score_a),
        .score_b       (score_b),
        .last_hit_a    (last_hit_a),
        .last_hit_b    (last_hit_b),
        .winner        (winner),
        .final_score_a (final_score_a),
        .final_score_b (final_score_b)
    );

    // 50 MHz-style free-running clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of buttons and timer, then sample just after the edge.
    task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic [19:0] t);
        @(negedge clock);
        a_input       = a;
        b_input       = b;
        pattern_timer = t;
        @(posedge clock);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Check both scores and both hit reports in one go.
    task automatic check_players(input string tag, input int sa, input int sb, input logic [1:0] ha, input logic [1:0] hb);
        check_output({tag, ".score_a"},    16'(score_a),    16'(sa));
        check_output({tag, ".score_b"},    16'(score_b),    16'(sb));
        check_output({tag, ".last_hit_a"}, 16'(last_hit_a), 16'(ha));
        check_output({tag, ".last_hit_b"}, 16'(last_hit_b), 16'(hb));
    endtask

    // Check the game-over latch outputs.
    task automatic check_latch(input string tag, input logic [1:0] w, input int fa, input int fb);
        check_output({tag, ".winner"},  16'(winner),        16'(w));
        check_output({tag, ".final_a"}, 16'(final_score_a), 16'(fa));
        check_output({tag, ".final_b"}, 16'(final_score_b), 16'(fb));
    endtask

    // Linear directed sequence.
    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        game_active   = 1'b0;
        game_over     = 1'b0;
        a_input       = 4'b0000;
        b_input       = 4'b0000;
        pattern_a     = UP;
        pattern_b     = DOWN;
        pattern_valid = 1'b0;
        pattern_timer = '0;

        #1 reset = 1'b1;
        #2;
        check_players("reset", 0, 0, 2'b00, 2'b00);
        check_latch("reset", 2'b00, 0, 0);

        @(negedge clock);
        reset         = 1'b0;
        game_active   = 1'b1;
        pattern_valid = 1'b1;

        // Perfect press for A, then the pulse drops.
        apply_stimulus(UP, 4'b0000, 20'd0);
        check_players("perfectA", 10, 0, 2'b10, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        check_players("pulseA", 10, 0, 2'b00, 2'b00);

        // Good press for B just past the perfect window.
        apply_stimulus(4'b0000, DOWN, 20'd125001);
        check_players("goodB", 10, 5, 2'b00, 2'b01);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);

        // Both correct but past every window: no change.
        apply_stimulus(UP, DOWN, 20'd500001);
        check_players("lateBoth", 10, 5, 2'b00, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);

        // Wrong presses for A, saturating at zero.
        apply_stimulus(DOWN, 4'b0000, 20'd100000);
        check_players("wrongA1", 5, 5, 2'b11, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(DOWN, 4'b0000, 20'd100000);
        check_players("wrongA2", 0, 5, 2'b11, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(DOWN, 4'b0000, 20'd100000);
        check_players("wrongA3", 0, 5, 2'b11, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);

        // Window boundaries for B.
        apply_stimulus(4'b0000, UP, 20'd500000);
        check_players("wrongBedge", 0, 0, 2'b00, 2'b11);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(4'b0000, DOWN, 20'd250000);
        check_players("goodBedge", 0, 5, 2'b00, 2'b01);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(4'b0000, DOWN, 20'd250001);
        check_players("missBedge", 0, 5, 2'b00, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);

        // Press while patterns are invalid is ignored.
        pattern_valid = 1'b0;
        apply_stimulus(UP, 4'b0000, 20'd0);
        check_players("disabledA", 0, 5, 2'b00, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        pattern_valid = 1'b1;

        // Multi-bit press is wrong; then perfect at the edge; then a penalty.
        apply_stimulus(4'b0101, 4'b0000, 20'd0);
        check_players("multiA", 0, 5, 2'b11, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(UP, 4'b0000, 20'd125000);
        check_players("perfAedge", 10, 5, 2'b10, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        apply_stimulus(DOWN, 4'b0000, 20'd0);
        check_players("wrongA4", 5, 5, 2'b11, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);

        // Tie at game over, scores frozen afterwards.
        game_over = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        check_latch("tie", 2'b11, 5, 5);
        apply_stimulus(UP, DOWN, 20'd0);
        check_players("frozen", 5, 5, 2'b00, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        game_over = 1'b0;
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        check_latch("tieHold", 2'b11, 5, 5);

        // Fresh game where A wins.
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        apply_stimulus(UP, 4'b0000, 20'd0);
        check_players("newGame", 10, 0, 2'b10, 2'b00);
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        game_over = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 20'd0);
        check_latch("winA", 2'b01, 10, 0);
        game_over = 1'b0;

        // Held button scores once, then reset mid-hold clears everything at once.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(UP, 4'b0000, 20'd0);
        end
        check_players("hold", 20, 0, 2'b00, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_players("midReset", 0, 0, 2'b00, 2'b00);
        check_latch("midReset", 2'b00, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_system_test.md
SCORE_SYSTEM_TEST -- requirements
Module: score_system_test

Interface
REQ-001 Parameters (name, default, meaning): PERFECT_WINDOW 125000, perfect timer limit; GOOD_WINDOW 250000, good timer limit; TOTAL_WINDOW 500000, penalty-eligible timer limit; PERFECT_POINTS 10; GOOD_POINTS 5; PENALTY_POINTS 5; SCORE_MAX 9999.
REQ-002 Clocking and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-003 clock  in  1  system clock, 50 MHz.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 game_active  in  1  scoring enable.
REQ-006 game_over  in  1  freezes scores; triggers winner and final-score latch.
REQ-007 a_input / b_input  in  4  player buttons, one-hot: UP 0001, DOWN 0010, LEFT 0100, RIGHT 1000.
REQ-008 pattern_a / pattern_b  in  4  expected button per player.
REQ-009 pattern_valid  in  1  patterns and timer are meaningful.
REQ-010 pattern_timer  in  20  clock cycles since the current pattern appeared.
REQ-011 score_a / score_b  out  14  running scores.
REQ-012 last_hit_a / last_hit_b  out  2  per-press result: 10 perfect, 01 good, 00 miss or no event, 11 wrong button.
REQ-013 winner  out  2  00 undecided, 01 A, 10 B, 11 tie.
REQ-014 final_score_a / final_score_b  out  14  scores latched at game over.

Function
REQ-015 A press is detected when the player input is nonzero and its registered previous value is 0000; the previous value is registered every cycle regardless of enables.
REQ-016 Scoring is enabled only when game_active=1, pattern_valid=1 and game_over=0; a press while disabled is ignored.
REQ-017 A correct press has input equal to the pattern; any other nonzero input, including multiple bits set, is a wrong press.
REQ-018 Correct press, timer <= PERFECT_WINDOW: score += 10 and last_hit=10.
REQ-019 Correct press, PERFECT_WINDOW < timer <= GOOD_WINDOW: score += 5 and last_hit=01.
REQ-020 Correct press, timer > GOOD_WINDOW: score unchanged and last_hit=00.
REQ-021 Wrong press, timer <= TOTAL_WINDOW: score -= 5, saturating at 0, and last_hit=11.
REQ-022 Wrong press, timer > TOTAL_WINDOW: ignored; last_hit=00.
REQ-023 Additions saturate at SCORE_MAX.
REQ-024 Latency is one cycle: score and last_hit are registered at the posedge that samples the press.
REQ-025 last_hit is a one-cycle pulse and returns to 00 on the next cycle.
REQ-026 Players A and B are fully independent; simultaneous presses are both scored in the same cycle.
REQ-027 On the first cycle with game_over=1, final_score_a/b latch score_a/b and winner is set: A>B gives 01, B>A gives 10, equal gives 11.
REQ-028 winner and final scores hold until reset; a later game_over deassertion does not clear them.
REQ-029 While game_over=1, scores are frozen.

Reset
REQ-030 Asynchronous reset clears to zero: score_a/b, last_hit_a/b (00), winner (00), final_score_a/b, previous-input registers and the game-over latch flag.
REQ-031 Reset asserted mid-game takes effect immediately; no press is scored in the deassertion cycle unless it is a fresh 0 to nonzero transition.

Structure
REQ-032 A shared package holds window constants, point values, SCORE_MAX, button encodings, and the last_hit and winner encodings.
REQ-033 One sub-module, score_tracker, is instantiated once per player and covers: edge detect, classification, score register and last_hit.
REQ-034 The top level holds the winner and final-score latch.
REQ-035 Implementation is approximately 150-250 lines of RTL in total.

Verification
REQ-036 Reset, then game_active=1, pattern_valid=1, pattern_a=UP, timer=0, a_input=UP for one cycle -> score_a=10 and last_hit_a=10 for one cycle.
REQ-037 pattern_b=DOWN, timer=125001, b_input=DOWN for one cycle -> score_b=5 and last_hit_b=01.
REQ-038 timer=500001, a_input=UP and b_input=DOWN together -> scores unchanged (10/5) and both last_hit=00.
REQ-039 timer=100000, a_input=DOWN against pattern UP -> score_a=5 and last_hit_a=11; repeating from score 0 keeps score_a=0.
REQ-040 With scores 5/5, assert game_over -> next cycle winner=11 and final scores 5/5; later presses do not change any score.
REQ-041 Hold a_input=UP for 10 cycles -> exactly one score increment; assert reset mid-hold -> all outputs are 0 immediately.
